// File: rtl/ucode_branch_ctrl.sv
// Microprogram branch controller: registers one microword and decodes its
// next-address op, condition select and loop counter into sequencer commands.
module ucode_branch_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic [55:0] rom_data,
  input  logic [13:0] cond_in,
  output logic [1:0]  seq_op,
  output logic [11:0] seq_din,
  output logic [33:0] ctl_out,
  output logic [11:0] ctr_value,
  output logic        ctr_zero,
  output logic        illegal
);

  localparam logic [1:0] OP_CONT = 2'b00;
  localparam logic [1:0] OP_JUMP = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  localparam logic [3:0] NOP_CONT  = 4'd0;
  localparam logic [3:0] NOP_JMP   = 4'd1;
  localparam logic [3:0] NOP_JMPC  = 4'd2;
  localparam logic [3:0] NOP_CALL  = 4'd3;
  localparam logic [3:0] NOP_CALLC = 4'd4;
  localparam logic [3:0] NOP_RET   = 4'd5;
  localparam logic [3:0] NOP_RETC  = 4'd6;
  localparam logic [3:0] NOP_LDCT  = 4'd7;
  localparam logic [3:0] NOP_LOOP  = 4'd8;
  localparam logic [3:0] NOP_WAIT  = 4'd9;

  logic [55:0] r_pipe;
  logic [11:0] r_ctr;
  logic        r_illegal;

  logic [11:0] w_addr;
  logic [3:0]  w_nop;
  logic [3:0]  w_csel;
  logic        w_cpol;
  logic [15:0] w_cond_vec;
  logic        w_cond;
  logic        w_ctr_zero;
  logic        w_unused_rsvd;

  assign w_addr        = r_pipe[11:0];
  assign w_nop         = r_pipe[15:12];
  assign w_csel        = r_pipe[19:16];
  assign w_cpol        = r_pipe[20];
  assign w_unused_rsvd = r_pipe[21];
  assign w_ctr_zero    = (r_ctr == 12'd0);

  // Index 0 is the always-true select, 15 is the loop counter's zero flag.
  assign w_cond_vec = {w_ctr_zero, cond_in, 1'b1};
  assign w_cond     = w_cond_vec[w_csel] ^ w_cpol;

  assign ctl_out   = r_pipe[55:22];
  assign seq_din   = w_addr;
  assign ctr_value = r_ctr;
  assign ctr_zero  = w_ctr_zero;
  assign illegal   = r_illegal;

  always_comb begin
    seq_op = OP_CONT;
    case (w_nop)
      NOP_JMP:   seq_op = OP_JUMP;
      NOP_JMPC:  seq_op = w_cond ? OP_JUMP : OP_CONT;
      NOP_CALL:  seq_op = OP_CALL;
      NOP_CALLC: seq_op = w_cond ? OP_CALL : OP_CONT;
      NOP_RET:   seq_op = OP_RET;
      NOP_RETC:  seq_op = w_cond ? OP_RET : OP_CONT;
      NOP_LOOP:  seq_op = w_ctr_zero ? OP_CONT : OP_JUMP;
      NOP_WAIT:  seq_op = w_cond ? OP_CONT : OP_JUMP;
      default:   seq_op = OP_CONT;
    endcase
  end

  // LOOP decides from the pre-edge count; the decrement saturates at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pipe    <= '0;
      r_ctr     <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_pipe <= rom_data;
      if (w_nop == NOP_LDCT) begin
        r_ctr <= w_addr;
      end else if (w_nop == NOP_LOOP && !w_ctr_zero) begin
        r_ctr <= r_ctr - 12'd1;
      end
      if (w_nop >= 4'd10) begin
        r_illegal <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ucode_branch_ctrl.sv
// Scoreboard bench for ucode_branch_ctrl: each driven microword queues the
// outputs expected during the following cycle; a monitor pops and compares.
module tb_ucode_branch_ctrl;

  logic        clock;
  logic        reset;
  logic [55:0] rom_data;
  logic [13:0] cond_in;
  logic [1:0]  seq_op;
  logic [11:0] seq_din;
  logic [33:0] ctl_out;
  logic [11:0] ctr_value;
  logic        ctr_zero;
  logic        illegal;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] din;
    logic [33:0] ctl;
    logic [11:0] ctr;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  ucode_branch_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .rom_data  (rom_data),
    .cond_in   (cond_in),
    .seq_op    (seq_op),
    .seq_din   (seq_din),
    .ctl_out   (ctl_out),
    .ctr_value (ctr_value),
    .ctr_zero  (ctr_zero),
    .illegal   (illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [55:0] mk(input logic [11:0] addr, input logic [3:0] nop,
                                     input logic [3:0] csel, input logic cpol);
    logic [33:0] ctl;
    ctl = {22'h0, addr} ^ 34'h3_C3C3_0F0F ^ {30'h0, nop};
    return {ctl, 1'b1, cpol, csel, nop, addr};
  endfunction

  // Present one word (optionally with reset), then set cond_in for the cycle
  // in which that word sits in the pipeline.
  task automatic drive(input logic [55:0] word, input logic [13:0] cond, input logic rst,
                       input logic [1:0] e_op, input logic [11:0] e_ctr, input logic e_ill);
    exp_t e;
    @(negedge clock);
    reset    = rst;
    rom_data = word;
    e.op  = e_op;
    e.din = rst ? 12'h0 : word[11:0];
    e.ctl = rst ? 34'h0 : word[55:22];
    e.ctr = e_ctr;
    e.ill = e_ill;
    sb_q.push_back(e);
    @(posedge clock);
    #1 cond_in = cond;
  endtask

  always @(posedge clock) begin
    exp_t e;
    #2;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val("seq_op",    64'(seq_op),    64'(e.op));
      check_val("seq_din",   64'(seq_din),   64'(e.din));
      check_val("ctl_out",   64'(ctl_out),   64'(e.ctl));
      check_val("ctr_value", 64'(ctr_value), 64'(e.ctr));
      check_val("ctr_zero",  64'(ctr_zero),  64'(e.ctr == 12'h0));
      check_val("illegal",   64'(illegal),   64'(e.ill));
    end
  end

  initial begin
    int budget;
    reset    = 1'b1;
    rom_data = mk(12'hABC, 4'd12, 4'd0, 1'b0);
    cond_in  = '0;
    repeat (2) @(posedge clock);
    #1;
    check_val("rst_seq_op",   64'(seq_op),    64'h0);
    check_val("rst_seq_din",  64'(seq_din),   64'h0);
    check_val("rst_ctl_out",  64'(ctl_out),   64'h0);
    check_val("rst_ctr",      64'(ctr_value), 64'h0);
    check_val("rst_ctr_zero", 64'(ctr_zero),  64'h1);
    check_val("rst_illegal",  64'(illegal),   64'h0);

    // Conditional jump on cond_in[2] with both polarities
    drive(mk(12'h123, 4'd2, 4'd3, 1'b0), 14'h0004, 1'b0, 2'b01, 12'd0, 1'b0);
    drive(mk(12'h123, 4'd2, 4'd3, 1'b0), 14'h0000, 1'b0, 2'b00, 12'd0, 1'b0);
    drive(mk(12'h123, 4'd2, 4'd3, 1'b1), 14'h0004, 1'b0, 2'b00, 12'd0, 1'b0);
    drive(mk(12'h123, 4'd2, 4'd3, 1'b1), 14'h0000, 1'b0, 2'b01, 12'd0, 1'b0);
    drive(mk(12'h456, 4'd2, 4'd14, 1'b0), 14'h2000, 1'b0, 2'b01, 12'd0, 1'b0);
    drive(mk(12'h456, 4'd2, 4'd14, 1'b0), 14'h1FFF, 1'b0, 2'b00, 12'd0, 1'b0);

    // Load counter 3 and loop until it reaches 0, then stay there
    drive(mk(12'd3,   4'd7, 4'd0, 1'b0), 14'h0, 1'b0, 2'b00, 12'd0, 1'b0);
    drive(mk(12'h040, 4'd8, 4'd0, 1'b0), 14'h0, 1'b0, 2'b01, 12'd3, 1'b0);
    drive(mk(12'h040, 4'd8, 4'd0, 1'b0), 14'h0, 1'b0, 2'b01, 12'd2, 1'b0);
    drive(mk(12'h040, 4'd8, 4'd0, 1'b0), 14'h0, 1'b0, 2'b01, 12'd1, 1'b0);
    drive(mk(12'h040, 4'd8, 4'd0, 1'b0), 14'h0, 1'b0, 2'b00, 12'd0, 1'b0);
    drive(mk(12'h040, 4'd8, 4'd0, 1'b0), 14'h0, 1'b0, 2'b00, 12'd0, 1'b0);

    // Call/return variants
    drive(mk(12'h777, 4'd5, 4'd0, 1'b0), 14'h0, 1'b0, 2'b11, 12'd0, 1'b0);
    drive(mk(12'h2AB, 4'd4, 4'd0, 1'b0), 14'h0, 1'b0, 2'b10, 12'd0, 1'b0);
    drive(mk(12'h2AC, 4'd3, 4'd5, 1'b0), 14'h0, 1'b0, 2'b10, 12'd0, 1'b0);
    drive(mk(12'h011, 4'd6, 4'd1, 1'b0), 14'h0001, 1'b0, 2'b11, 12'd0, 1'b0);
    drive(mk(12'h011, 4'd6, 4'd1, 1'b0), 14'h3FFE, 1'b0, 2'b00, 12'd0, 1'b0);

    // WAIT on the counter-zero select
    drive(mk(12'd2,   4'd7, 4'd0,  1'b0), 14'h0, 1'b0, 2'b00, 12'd0, 1'b0);
    drive(mk(12'h055, 4'd9, 4'd15, 1'b0), 14'h0, 1'b0, 2'b01, 12'd2, 1'b0);
    drive(mk(12'd0,   4'd7, 4'd0,  1'b0), 14'h0, 1'b0, 2'b00, 12'd2, 1'b0);
    drive(mk(12'h055, 4'd9, 4'd15, 1'b0), 14'h0, 1'b0, 2'b00, 12'd0, 1'b0);

    // Undefined op sets a sticky flag
    drive(mk(12'h0F0, 4'd12, 4'd0, 1'b0), 14'h0, 1'b0, 2'b00, 12'd0, 1'b0);
    drive(mk(12'h0F1, 4'd0,  4'd0, 1'b0), 14'h0, 1'b0, 2'b00, 12'd0, 1'b1);
    drive(mk(12'h7FF, 4'd1,  4'd0, 1'b0), 14'h0, 1'b0, 2'b01, 12'd0, 1'b1);

    // Reset in the middle of a loop aborts it and clears the flag
    drive(mk(12'd5,   4'd7, 4'd0, 1'b0), 14'h0, 1'b0, 2'b00, 12'd0, 1'b1);
    drive(mk(12'h040, 4'd8, 4'd0, 1'b0), 14'h0, 1'b0, 2'b01, 12'd5, 1'b1);
    drive(mk(12'h040, 4'd8, 4'd0, 1'b0), 14'h0, 1'b0, 2'b01, 12'd4, 1'b1);
    drive(mk(12'h040, 4'd8, 4'd0, 1'b0), 14'h0, 1'b1, 2'b00, 12'd0, 1'b0);
    drive(mk(12'h333, 4'd0, 4'd0, 1'b0), 14'h0, 1'b0, 2'b00, 12'd0, 1'b0);

    budget = 20;
    while (sb_q.size() > 0 && budget > 0) begin
      @(posedge clock);
      budget--;
    end
    #5;
    check_val("scoreboard_drained", 64'(sb_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
